// File: rtl/bcd_alu_seq.sv
// bcd_alu_seq: multi-cycle signed BCD ALU on NDIGITS-digit sign-magnitude operands.
// Add/sub run one digit per cycle (LSD first); multiply is repeated full-width BCD
// addition per multiplier digit; divide is restoring digit division.
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   start, opcode, op1, op2  request (sampled only while idle) and its operands
//   busy                     high whenever not idle
//   done                     one-cycle pulse; result and flags valid with it
//   result                   sign-magnitude BCD result, held until the next done
//   overflow, div_zero, bad_input  error flags, valid with done
module bcd_alu_seq #(
    parameter int unsigned NDIGITS = 4,
    localparam int unsigned W = 4 * NDIGITS + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   opcode,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         div_zero,
    output logic         bad_input
);

    localparam int unsigned M  = 4 * NDIGITS;  // magnitude width
    localparam int unsigned MW = M + 4;        // one spare digit for carries / remainder
    localparam int unsigned CW = $clog2(NDIGITS) + 1;
    localparam logic [CW-1:0] LastDig = CW'(NDIGITS - 1);

    localparam logic [2:0] OpAdd = 3'b001;
    localparam logic [2:0] OpSub = 3'b010;
    localparam logic [2:0] OpMul = 3'b011;
    localparam logic [2:0] OpDiv = 3'b100;

    typedef enum logic [2:0] {StIdle, StCheck, StAddSub, StMul, StDiv, StFinish} state_e;

    // One decimal digit of x + y + cin, or x + (9 - y) + cin (nine's complement subtract).
    // Returns {carry, digit}.
    function automatic logic [4:0] dig_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin, input logic sub);
        logic [3:0] yy;
        logic [4:0] s;
        yy = sub ? (4'd9 - y) : y;
        s  = {1'b0, x} + {1'b0, yy} + {4'b0, cin};
        if (s > 5'd9) s = s + 5'd6;
        return s;
    endfunction

    // Full-width (NDIGITS+1 digit) BCD add or subtract; subtract assumes x >= y.
    function automatic logic [MW-1:0] bcd_add_w(input logic [MW-1:0] x, input logic [MW-1:0] y,
                                                input logic sub);
        logic [MW-1:0] r;
        logic [4:0]    s;
        logic          c;
        r = '0;
        c = sub;
        for (int i = 0; i < int'(NDIGITS) + 1; i++) begin
            s = dig_add(x[4*i +: 4], y[4*i +: 4], c, sub);
            r[4*i +: 4] = s[3:0];
            c = s[4];
        end
        return r;
    endfunction

    function automatic logic has_bad_digit(input logic [M-1:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < int'(NDIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) b = 1'b1;
        end
        return b;
    endfunction

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [M-1:0]    a_q, a_d;        // |op1|, or larger magnitude for add/sub
    logic [M-1:0]    b_q, b_d;        // |op2|, or smaller magnitude for add/sub
    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic [MW-1:0]   acc_q, acc_d;    // product accumulator / division remainder
    logic [M-1:0]    quot_q, quot_d;  // add/sub sum digits or quotient digits
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      rep_q, rep_d;
    logic            phase_q, phase_d; // mul/div: 0 = shift cycle, 1 = add/subtract cycles
    logic            carry_q, carry_d;
    logic            sub_q, sub_d;
    logic            rsign_q, rsign_d;
    logic            ovf_q, ovf_d;
    logic            bad_q, bad_d;
    logic            dz_q, dz_d;
    logic [W-1:0]    result_q, result_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;
    logic            div_zero_q, div_zero_d;
    logic            bad_input_q, bad_input_d;

    logic [4:0]      dsum;
    logic [MW-1:0]   wsum;
    logic [M-1:0]    mag;
    logic            s2e;
    logic            last_dig;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        acc_d       = acc_q;
        quot_d      = quot_q;
        cnt_d       = cnt_q;
        rep_d       = rep_q;
        phase_d     = phase_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        rsign_d     = rsign_q;
        ovf_d       = ovf_q;
        bad_d       = bad_q;
        dz_d        = dz_q;
        result_d    = result_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        div_zero_d  = div_zero_q;
        bad_input_d = bad_input_q;
        dsum        = '0;
        wsum        = '0;
        mag         = '0;
        s2e         = s2_q ^ (op_q == OpSub);
        last_dig    = (cnt_q == LastDig);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d        = opcode;
                    a_d         = op1[M-1:0];
                    b_d         = op2[M-1:0];
                    s1_d        = op1[W-1];
                    s2_d        = op2[W-1];
                    ovf_d       = 1'b0;
                    bad_d       = 1'b0;
                    dz_d        = 1'b0;
                    overflow_d  = 1'b0;
                    div_zero_d  = 1'b0;
                    bad_input_d = 1'b0;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                cnt_d   = '0;
                rep_d   = '0;
                phase_d = 1'b0;
                acc_d   = '0;
                quot_d  = '0;
                rsign_d = s1_q ^ s2_q;
                if (!(op_q inside {OpAdd, OpSub, OpMul, OpDiv}) ||
                    has_bad_digit(a_q) || has_bad_digit(b_q)) begin
                    bad_d   = 1'b1;
                    state_d = StFinish;
                end else if (op_q == OpDiv && b_q == '0) begin
                    dz_d    = 1'b1;
                    state_d = StFinish;
                end else if (op_q == OpMul) begin
                    state_d = StMul;
                end else if (op_q == OpDiv) begin
                    state_d = StDiv;
                end else begin
                    state_d = StAddSub;
                    if (s1_q == s2e) begin
                        sub_d   = 1'b0;
                        carry_d = 1'b0;
                        rsign_d = s1_q;
                    end else begin
                        // Subtract smaller magnitude from larger; BCD orders like binary.
                        sub_d   = 1'b1;
                        carry_d = 1'b1;
                        if (a_q >= b_q) begin
                            rsign_d = s1_q;
                        end else begin
                            a_d     = b_q;
                            b_d     = a_q;
                            rsign_d = s2e;
                        end
                    end
                end
            end
            StAddSub: begin
                dsum    = dig_add(a_q[3:0], b_q[3:0], carry_q, sub_q);
                quot_d  = {dsum[3:0], quot_q[M-1:4]};
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = dsum[4];
                cnt_d   = cnt_q + 1'b1;
                if (last_dig) begin
                    ovf_d   = dsum[4] & ~sub_q;
                    state_d = StFinish;
                end
            end
            StMul: begin
                if (!phase_q) begin
                    if (acc_q[M-1 -: 4] != 4'd0) ovf_d = 1'b1;
                    acc_d = {4'b0, acc_q[M-5:0], 4'b0};
                    b_d   = b_q << 4;
                    if (b_q[M-1 -: 4] == 4'd0) begin
                        if (last_dig) state_d = StFinish;
                        else          cnt_d   = cnt_q + 1'b1;
                    end else begin
                        rep_d   = b_q[M-1 -: 4];
                        phase_d = 1'b1;
                    end
                end else begin
                    wsum  = bcd_add_w(acc_q, {4'b0, a_q}, 1'b0);
                    if (wsum[MW-1 -: 4] != 4'd0) ovf_d = 1'b1;
                    acc_d = {4'b0, wsum[M-1:0]};
                    rep_d = rep_q - 4'd1;
                    if (rep_q == 4'd1) begin
                        phase_d = 1'b0;
                        if (last_dig) state_d = StFinish;
                        else          cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            StDiv: begin
                if (!phase_q) begin
                    // Remainder stays below the divisor, so shifting in a digit cannot lose data.
                    acc_d   = {acc_q[M-1:0], a_q[M-1 -: 4]};
                    a_d     = a_q << 4;
                    rep_d   = '0;
                    phase_d = 1'b1;
                end else if (acc_q >= {4'b0, b_q}) begin
                    acc_d = bcd_add_w(acc_q, {4'b0, b_q}, 1'b1);
                    rep_d = rep_q + 4'd1;
                end else begin
                    quot_d  = {quot_q[M-5:0], rep_q};
                    phase_d = 1'b0;
                    if (last_dig) state_d = StFinish;
                    else          cnt_d   = cnt_q + 1'b1;
                end
            end
            StFinish: begin
                if (bad_q || dz_q)      mag = '0;
                else if (op_q == OpMul) mag = acc_q[M-1:0];
                else                    mag = quot_q;
                result_d    = {rsign_q & (mag != '0), mag};
                overflow_d  = ovf_q;
                div_zero_d  = dz_q;
                bad_input_d = bad_q;
                done_d      = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            acc_q       <= '0;
            quot_q      <= '0;
            cnt_q       <= '0;
            rep_q       <= '0;
            phase_q     <= 1'b0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            rsign_q     <= 1'b0;
            ovf_q       <= 1'b0;
            bad_q       <= 1'b0;
            dz_q        <= 1'b0;
            result_q    <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            div_zero_q  <= 1'b0;
            bad_input_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            acc_q       <= acc_d;
            quot_q      <= quot_d;
            cnt_q       <= cnt_d;
            rep_q       <= rep_d;
            phase_q     <= phase_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            rsign_q     <= rsign_d;
            ovf_q       <= ovf_d;
            bad_q       <= bad_d;
            dz_q        <= dz_d;
            result_q    <= result_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            div_zero_q  <= div_zero_d;
            bad_input_q <= bad_input_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign div_zero  = div_zero_q;
    assign bad_input = bad_input_q;

endmodule

// File: tb/tb_bcd_alu_seq.sv
// tb_bcd_alu_seq: directed test of bcd_alu_seq (NDIGITS=4) with an integer-arithmetic
// reference model and a per-cycle compare process, plus literal expectations per vector.
module tb_bcd_alu_seq;

    localparam int ND     = 4;
    localparam int W      = 4 * ND + 1;
    localparam int MAXLAT = 11 * ND + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   opcode;
    logic [W-1:0] op1, op2;
    logic         busy, done;
    logic [W-1:0] result;
    logic         overflow, div_zero, bad_input;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         dz;
        logic         bad;
        logic [2:0]   op;
        int           cyc;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    bcd_alu_seq #(.NDIGITS(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .op1       (op1),
        .op2       (op2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .div_zero  (div_zero),
        .bad_input (bad_input)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [4*ND-1:0] b);
        int r = 0;
        for (int i = ND - 1; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [4*ND-1:0] int2bcd(input int v);
        logic [4*ND-1:0] b;
        int t = v;
        for (int i = 0; i < ND; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    function automatic logic bad_digits(input logic [W-1:0] v);
        logic r = 1'b0;
        for (int i = 0; i < ND; i++) if (v[4*i +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    // Reference: decode to integers, do the arithmetic, re-encode.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t e;
        int   m1, m2, v, mag;
        logic sg;
        e.res = '0; e.ovf = 1'b0; e.dz = 1'b0; e.op = op; e.cyc = cyc;
        e.bad = !(op inside {3'd1, 3'd2, 3'd3, 3'd4}) || bad_digits(x) || bad_digits(y);
        if (e.bad) return e;
        m1  = bcd2int(x[W-2:0]);
        m2  = bcd2int(y[W-2:0]);
        sg  = 1'b0;
        mag = 0;
        case (op)
            3'd1, 3'd2: begin
                v   = (x[W-1] ? -m1 : m1) + ((y[W-1] ^ (op == 3'd2)) ? -m2 : m2);
                sg  = (v < 0);
                mag = (v < 0) ? -v : v;
            end
            3'd3: begin
                mag = m1 * m2;
                sg  = x[W-1] ^ y[W-1];
            end
            default: begin
                if (m2 == 0) begin
                    e.dz = 1'b1;
                    return e;
                end
                mag = m1 / m2;
                sg  = x[W-1] ^ y[W-1];
            end
        endcase
        e.ovf = (mag > 10 ** ND - 1);
        mag   = mag % (10 ** ND);
        e.res = {sg && (mag != 0), int2bcd(mag)};
        return e;
    endfunction

    // Compare process: every done is checked against the model's queued expectation.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        cyc++;
        if (rst) begin
            q.delete();
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_result", 32'(result), 0);
            check("rst_flags", 32'({overflow, div_zero, bad_input}), 0);
        end else begin
            if (done) begin
                check("done_busy", 32'(busy), 0);
                check("done_pending", 32'(q.size()), 1);
                if (q.size() > 0) begin
                    e   = q.pop_front();
                    lat = cyc - e.cyc - 1;
                    check("mdl_result", 32'(result), 32'(e.res));
                    check("mdl_flags", 32'({overflow, div_zero, bad_input}),
                          32'({e.ovf, e.dz, e.bad}));
                    if (e.bad || e.dz)                     check("lat_err", lat, 2);
                    else if (e.op == 3'd1 || e.op == 3'd2) check("lat_addsub", lat, ND + 2);
                    else                                   check("lat_bound",
                                                                 32'(lat <= MAXLAT), 1);
                end
            end
            if (start && !busy) q.push_back(model(opcode, op1, op2));
        end
    end

    task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        opcode = op; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_check(input string name, input logic [W-1:0] exp_res,
                              input logic [2:0] exp_flags);
        for (int i = 0; i < MAXLAT + 10; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check({name, "_done"}, 32'(done), 1);
        check({name, "_res"}, 32'(result), 32'(exp_res));
        check({name, "_flags"}, 32'({overflow, div_zero, bad_input}), 32'(exp_flags));
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic [2:0] exp_flags);
        launch(op, a, b);
        wait_check(name, exp_res, exp_flags);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        rst = 1'b1; start = 1'b0; opcode = '0; op1 = '0; op2 = '0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // flags are {overflow, div_zero, bad_input}
        run_op("add_carry",  3'b001, 17'h0_0999, 17'h0_0001, 17'h0_1000, 3'b000);
        run_op("sub_neg",    3'b010, 17'h0_0025, 17'h0_0100, 17'h1_0075, 3'b000);
        run_op("add_zero",   3'b001, 17'h1_0050, 17'h0_0050, 17'h0_0000, 3'b000);
        run_op("add_ovf",    3'b001, 17'h0_9999, 17'h0_0001, 17'h0_0000, 3'b100);
        run_op("sub_mixed",  3'b010, 17'h0_0005, 17'h1_0007, 17'h0_0012, 3'b000);
        run_op("sub_eq",     3'b010, 17'h1_0300, 17'h1_0300, 17'h0_0000, 3'b000);
        run_op("mul_ovf",    3'b011, 17'h0_0120, 17'h1_0099, 17'h1_1880, 3'b100);
        run_op("mul_negneg", 3'b011, 17'h1_0012, 17'h1_0011, 17'h0_0132, 3'b000);
        run_op("mul_big",    3'b011, 17'h0_9999, 17'h0_9999, 17'h0_0001, 3'b100);
        run_op("div_neg",    3'b100, 17'h1_1000, 17'h0_0007, 17'h1_0142, 3'b000);
        run_op("div_3333",   3'b100, 17'h0_9999, 17'h0_0003, 17'h0_3333, 3'b000);
        run_op("div_trunc0", 3'b100, 17'h0_0005, 17'h1_0009, 17'h0_0000, 3'b000);
        run_op("div_zero",   3'b100, 17'h0_0123, 17'h0_0000, 17'h0_0000, 3'b010);
        run_op("bad_digit",  3'b001, 17'h0_00A0, 17'h0_0001, 17'h0_0000, 3'b001);
        run_op("bad_opcode", 3'b111, 17'h0_0001, 17'h0_0001, 17'h0_0000, 3'b001);

        // Start while busy is ignored.
        launch(3'b011, 17'h0_9999, 17'h0_9999);
        repeat (3) @(posedge clk); #1;
        opcode = 3'b001; op1 = 17'h0_0001; op2 = 17'h0_0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_check("busy_ignore", 17'h0_0001, 3'b100);

        // Start in the done cycle is accepted.
        launch(3'b001, 17'h0_0010, 17'h0_0020);
        repeat (ND + 2) @(posedge clk); #1;
        opcode = 3'b010; op1 = 17'h0_0010; op2 = 17'h0_0020; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_check("b2b_sub", 17'h1_0010, 3'b000);

        // Reset mid-multiply aborts without done.
        launch(3'b011, 17'h0_9999, 17'h0_9999);
        repeat (5) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        repeat (MAXLAT + 10) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("rst_no_done", nd, 0);
        check("rst_idle", 32'(busy), 0);
        run_op("post_rst", 3'b001, 17'h0_1234, 17'h0_4321, 17'h0_5555, 3'b000);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
